// File: rtl/screen_pkg.sv
// Shared encodings and constants for the game-screen sequencer.
// PAUSE_EN widens the state encoding to make room for the PAUSE screen.
package screen_pkg;

`ifdef PAUSE_EN
   localparam int STATE_W = 3;
`else
   localparam int STATE_W = 2;
`endif

   localparam int           COLOR_W     = 16;
   localparam int           FRAME_W     = 10;
   localparam logic [15:0]  WHITE       = 16'hFFFF;
   localparam logic [15:0]  SKY_DEFAULT = 16'h6DFF;
   localparam logic [9:0]   FRAME_MAX   = 10'h3FF;

`ifdef PAUSE_EN
   typedef enum logic [STATE_W-1:0] {
      TITLE = 3'd0,
      PLAY  = 3'd1,
      DYING = 3'd2,
      ACK   = 3'd3,
      PAUSE = 3'd4
   } state_t;
`else
   typedef enum logic [STATE_W-1:0] {
      TITLE = 2'd0,
      PLAY  = 2'd1,
      DYING = 2'd2,
      ACK   = 2'd3
   } state_t;
`endif

endpackage

// File: rtl/screen_sequencer_frame_tick.sv
// Frame origin detector: one-cycle tick, one clock after the scan reaches (0,0),
// once per frame regardless of how long the origin is held.
module frame_tick (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] x,
   input  logic [8:0] y,
   output logic       tick
);

   logic origin_q;
   logic origin_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         origin_q <= 1'b0;
         origin_d <= 1'b0;
      end else begin
         origin_q <= (x == 10'd0) && (y == 9'd0);
         origin_d <= origin_q;
      end
   end

   assign tick = origin_q & ~origin_d;

endmodule

// File: rtl/screen_sequencer.sv
// Game-screen controller: sequences TITLE/PLAY/DYING/ACK, tracks lives and
// merges layer colours. Define PAUSE_EN to add the PAUSE screen.
//
//  state | meaning
//  TITLE | title overlay shown, wait for start press
//  PLAY  | game running, physics enabled
//  DYING | death animation, hold DYING_FRAMES frames
//  ACK   | end/clear screen, wait for press or ACK_FRAMES frames
//  PAUSE | (PAUSE_EN) game frozen, PLAY colours shown
module screen_sequencer
   import screen_pkg::*;
#(
   parameter logic [1:0]  LIVES        = 2'd3,
   parameter logic [9:0]  DYING_FRAMES = 10'd120,
   parameter logic [9:0]  ACK_FRAMES   = 10'd600,
   parameter logic [15:0] SKY_COLOR    = SKY_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9:0]         x,
   input  logic [8:0]         y,
   input  logic               btn_start,
   input  logic               player_dead,
   input  logic               level_clear,
   input  logic [COLOR_W-1:0] title_color,
   input  logic               title_vld,
   input  logic [COLOR_W-1:0] sprite_color,
   input  logic               sprite_vld,
   input  logic [COLOR_W-1:0] bg_color,
   input  logic               bg_vld,
   input  logic [COLOR_W-1:0] ack_color,
   output logic               title_play,
   output logic               ack_play,
   output logic               game_run,
   output logic [1:0]         lives,
   output logic [STATE_W-1:0] state,
   output logic [COLOR_W-1:0] color
);

   logic               tick;
   logic               btn_q;
   logic               btn_rise;
   logic               dying_done;
   logic               ack_done;
   logic               frame_run;
   logic [FRAME_W-1:0] frames;
   logic [1:0]         lives_nxt;
   state_t             state_q;
   state_t             state_nxt;

   frame_tick u_frame_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .y     (y),
      .tick  (tick)
   );

   assign btn_rise   = btn_start & ~btn_q;
   assign dying_done = tick && (frames == DYING_FRAMES - 10'd1);
   assign ack_done   = tick && (frames == ACK_FRAMES - 10'd1);
`ifdef PAUSE_EN
   assign frame_run  = tick && (frames != FRAME_MAX) && (state_q != PAUSE);
`else
   assign frame_run  = tick && (frames != FRAME_MAX);
`endif
   assign state      = state_q;

   always_comb begin
      state_nxt = state_q;
      lives_nxt = lives;
      case (state_q)
         TITLE: begin
            if (btn_rise) begin
               state_nxt = PLAY;
               lives_nxt = LIVES;
            end
         end
         PLAY: begin
            if (level_clear)
               state_nxt = ACK;
            else if (player_dead)
               state_nxt = DYING;
`ifdef PAUSE_EN
            else if (btn_rise)
               state_nxt = PAUSE;
`endif
         end
         DYING: begin
            if (dying_done) begin
               lives_nxt = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
               state_nxt = (lives > 2'd1) ? PLAY : ACK;
            end
         end
         ACK: begin
            if (btn_rise || ack_done)
               state_nxt = TITLE;
         end
`ifdef PAUSE_EN
         PAUSE: begin
            if (btn_rise)
               state_nxt = PLAY;
         end
`endif
         default: state_nxt = TITLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= TITLE;
         title_play <= 1'b1;
         ack_play   <= 1'b0;
         game_run   <= 1'b0;
         lives      <= LIVES;
         frames     <= '0;
         btn_q      <= 1'b0;
         color      <= '0;
      end else begin
         btn_q      <= btn_start;
         state_q    <= state_nxt;
         title_play <= (state_nxt == TITLE);
         ack_play   <= (state_nxt == ACK);
         game_run   <= (state_nxt == PLAY);
         lives      <= lives_nxt;

         if (state_nxt != state_q)
            frames <= '0;
         else if (frame_run)
            frames <= frames + 10'd1;

         // Colour follows the screen currently displayed; overlays already lag by one clock.
         case (state_q)
            TITLE:   color <= title_vld ? title_color : WHITE;
            ACK:     color <= ack_color;
            default: color <= sprite_vld ? sprite_color :
                              bg_vld     ? bg_color     : SKY_COLOR;
         endcase
      end
   end

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer; frames are produced by pulsing the scan to the origin.
module tb_screen_sequencer;
   import screen_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [9:0]         x;
   logic [8:0]         y;
   logic               btn_start;
   logic               player_dead;
   logic               level_clear;
   logic [15:0]        title_color;
   logic               title_vld;
   logic [15:0]        sprite_color;
   logic               sprite_vld;
   logic [15:0]        bg_color;
   logic               bg_vld;
   logic [15:0]        ack_color;
   logic               title_play;
   logic               ack_play;
   logic               game_run;
   logic [1:0]         lives;
   logic [STATE_W-1:0] state;
   logic [15:0]        color;

   int n_checks = 0;
   int n_fails  = 0;

   screen_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .x            (x),
      .y            (y),
      .btn_start    (btn_start),
      .player_dead  (player_dead),
      .level_clear  (level_clear),
      .title_color  (title_color),
      .title_vld    (title_vld),
      .sprite_color (sprite_color),
      .sprite_vld   (sprite_vld),
      .bg_color     (bg_color),
      .bg_vld       (bg_vld),
      .ack_color    (ack_color),
      .title_play   (title_play),
      .ack_play     (ack_play),
      .game_run     (game_run),
      .lives        (lives),
      .state        (state),
      .color        (color)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One frame: origin for one clock, then away; the tick is consumed inside this task.
   task automatic frame();
      x = 10'd0;
      y = 9'd0;
      step();
      x = 10'd5;
      y = 9'd5;
      step();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic press();
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
   endtask

   task automatic die();
      player_dead = 1'b1;
      step();
      player_dead = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      x            = 10'd5;
      y            = 9'd5;
      btn_start    = 1'b0;
      player_dead  = 1'b0;
      level_clear  = 1'b0;
      title_color  = 16'h0000;
      title_vld    = 1'b0;
      sprite_color = 16'h0000;
      sprite_vld   = 1'b0;
      bg_color     = 16'h0000;
      bg_vld       = 1'b0;
      ack_color    = 16'hFFFF;
      step();
      step();
      check("rst_state", 32'(state), 32'd0);
      check("rst_title_play", 32'(title_play), 32'd1);
      check("rst_ack_play", 32'(ack_play), 32'd0);
      check("rst_game_run", 32'(game_run), 32'd0);
      check("rst_lives", 32'(lives), 32'd3);
      check("rst_color", 32'(color), 32'd0);
      rst_n = 1'b1;
      step();

      // Start press
      btn_start = 1'b1;
      step();
      check("start_state", 32'(state), 32'd1);
      check("start_title_play", 32'(title_play), 32'd0);
      check("start_game_run", 32'(game_run), 32'd1);
      check("start_lives", 32'(lives), 32'd3);
      btn_start = 1'b0;
      step();

      // Colour priority in PLAY
      sprite_vld = 1'b1; sprite_color = 16'hF800; bg_vld = 1'b1; bg_color = 16'h07E0;
      step();
      check("play_sprite", 32'(color), 32'hF800);
      sprite_vld = 1'b0;
      step();
      check("play_bg", 32'(color), 32'h07E0);
      bg_vld = 1'b0;
      step();
      check("play_sky", 32'(color), 32'h6DFF);

`ifdef PAUSE_EN
      press();
      check("pause_state", 32'(state), 32'd4);
      check("pause_game_run", 32'(game_run), 32'd0);
      die();
      frames(3);
      check("pause_ignores_dead", 32'(state), 32'd4);
      check("pause_color", 32'(color), 32'h6DFF);
      press();
      check("unpause_state", 32'(state), 32'd1);
      check("unpause_game_run", 32'(game_run), 32'd1);
`else
      press();
      check("play_btn_ignored", 32'(state), 32'd1);
`endif
      step();

      // Deaths: 120 frames each
      die();
      check("dying_state", 32'(state), 32'd2);
      check("dying_game_run", 32'(game_run), 32'd0);
      frames(119);
      check("dying_119", 32'(state), 32'd2);
      frame();
      check("respawn1_state", 32'(state), 32'd1);
      check("respawn1_lives", 32'(lives), 32'd2);
      die();
      frames(120);
      check("respawn2_state", 32'(state), 32'd1);
      check("respawn2_lives", 32'(lives), 32'd1);
      die();
      frames(120);
      check("gameover_state", 32'(state), 32'd3);
      check("gameover_lives", 32'(lives), 32'd0);
      check("gameover_ack_play", 32'(ack_play), 32'd1);
      ack_color = 16'h1234;
      step();
      check("ack_color", 32'(color), 32'h1234);

      // ACK timeout on exactly the 600th frame
      frames(599);
      check("ack_599", 32'(state), 32'd3);
      frame();
      check("ack_timeout", 32'(state), 32'd0);
      check("ack_timeout_title_play", 32'(title_play), 32'd1);
      title_vld = 1'b0;
      step();
      check("title_white", 32'(color), 32'hFFFF);
      title_vld = 1'b1; title_color = 16'hABCD;
      step();
      check("title_overlay", 32'(color), 32'hABCD);

      // Simultaneous clear and death: clear wins
      press();
      check("restart_lives", 32'(lives), 32'd3);
      level_clear = 1'b1; player_dead = 1'b1;
      step();
      level_clear = 1'b0; player_dead = 1'b0;
      check("clear_wins_state", 32'(state), 32'd3);
      check("clear_wins_lives", 32'(lives), 32'd3);

      // Early exit from ACK by button
      frames(5);
      press();
      check("ack_btn_exit", 32'(state), 32'd0);

      // Async reset during DYING
      step();
      press();
      die();
      frames(3);
      check("pre_rst_dying", 32'(state), 32'd2);
      check("pre_rst_color", 32'(color), 32'h6DFF);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_color", 32'(color), 32'd0);
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_title_play", 32'(title_play), 32'd1);
      check("async_rst_lives", 32'(lives), 32'd3);
      step();
      rst_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
